fpga_fabric: RTL and testbench

//  Configurable fabric: 4 pad banks (80 in/80 out per side), NUM_LE LUT4+FF logic elements, full-crossbar routing.

---
 rtl/fpga_fabric_pkg.sv | 54 +++++
 rtl/fpga_fabric_if.sv | 45 ++++
 rtl/fpga_fabric_le.sv | 52 +++++
 rtl/fpga_fabric.sv | 112 +++++++++++
 tb/tb_fpga_fabric.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_fabric_pkg.sv
// fpga_fabric_pkg: shared sizes and field layout for the configurable fabric.
//   - pad/LE/config dimensions and source-space bases
//   - LE configuration word layout (le_cfg_t)
//   - output selector placement helpers (word index / bit offset)
package fpga_fabric_pkg;

    localparam int IO_W          = 80;
    localparam int NUM_LE        = 64;
    localparam int CFG_W         = 384;
    localparam int CFG_WORDS     = 267;
    localparam int SEL_W         = 9;
    localparam int LE_INS        = 4;
    localparam int LUT_W         = 16;

    // Source space seen by every selector
    localparam int NUM_PADS      = 4 * IO_W;
    localparam int SRC_W         = 2 ** SEL_W;
    localparam int SRC_PAD_BASE  = 0;
    localparam int SRC_LE_BASE   = 320;
    localparam int SRC_ZERO_BASE = 384;

    // LE word field offsets
    localparam int LE_IN_LSB     = 0;
    localparam int LE_TT_LSB     = 36;
    localparam int LE_USE_FF_BIT = 52;
    localparam int LE_CE_EN_BIT  = 53;
    localparam int LE_CE_SEL_LSB = 54;
    localparam int LE_CFG_BITS   = 63;

    // Output selector words
    localparam int NUM_OUT       = NUM_PADS;
    localparam int OUT_WORD_BASE = 64;
    localparam int SEL_PER_WORD  = 42;
    localparam int OUT_WORDS     = (NUM_OUT + SEL_PER_WORD - 1) / SEL_PER_WORD;
    localparam int USED_WORDS    = OUT_WORD_BASE + OUT_WORDS;

    // Member order gives in_sel[0] at bit 0 and ce_sel at the top, matching the word layout.
    typedef struct packed {
        logic [SEL_W-1:0]             ce_sel;
        logic                         ce_en;
        logic                         use_ff;
        logic [LUT_W-1:0]             truth;
        logic [LE_INS-1:0][SEL_W-1:0] in_sel;
    } le_cfg_t;

    function automatic int out_word_idx(input int o);
        return OUT_WORD_BASE + (o / SEL_PER_WORD);
    endfunction

    function automatic int out_sel_lsb(input int o);
        return SEL_W * (o % SEL_PER_WORD);
    endfunction

endpackage

// File: rtl/fpga_fabric_if.sv
// fpga_fabric_if: pad, enable and configuration bus of the fabric.
//   top/bot/left/right_in  pad inputs (IO_W each)
//   top/bot/left/right_out pad outputs (IO_W each)
//   ff_en                  fabric run enable
//   configs_en/configs_in  multi-hot config word write
//   cfg_rd_addr/cfg_rd_data only with FPGA_FABRIC_CFG_READBACK_EN
// slave = fabric side, master = loader / bench side.
interface fpga_fabric_if;
    import fpga_fabric_pkg::*;

    logic [IO_W-1:0]      top_in;
    logic [IO_W-1:0]      bot_in;
    logic [IO_W-1:0]      left_in;
    logic [IO_W-1:0]      right_in;
    logic [IO_W-1:0]      top_out;
    logic [IO_W-1:0]      bot_out;
    logic [IO_W-1:0]      left_out;
    logic [IO_W-1:0]      right_out;
    logic                 ff_en;
    logic [CFG_WORDS-1:0] configs_en;
    logic [CFG_W-1:0]     configs_in;
`ifdef FPGA_FABRIC_CFG_READBACK_EN
    logic [SEL_W-1:0]     cfg_rd_addr;
    logic [CFG_W-1:0]     cfg_rd_data;
`endif

    modport slave (
        input  top_in, bot_in, left_in, right_in, ff_en, configs_en, configs_in,
`ifdef FPGA_FABRIC_CFG_READBACK_EN
        input  cfg_rd_addr,
        output cfg_rd_data,
`endif
        output top_out, bot_out, left_out, right_out
    );

    modport master (
        output top_in, bot_in, left_in, right_in, ff_en, configs_en, configs_in,
`ifdef FPGA_FABRIC_CFG_READBACK_EN
        output cfg_rd_addr,
        input  cfg_rd_data,
`endif
        input  top_out, bot_out, left_out, right_out
    );

endinterface

// File: rtl/fpga_fabric_le.sv
// fpga_le: one logic element = LUT4 + optional flip-flop with clock enable.
//   clock, rst        clock and synchronous active-high FF clear
//   ff_en_i           fabric enable; FF is held at 0 while low
//   truth_i           LUT truth table, indexed by {in3,in2,in1,in0}
//   use_ff_i          1 = registered output, 0 = LUT output
//   ce_en_i, ce_i     clock-enable select and the routed enable value
//   in_i              the four routed LUT input values
//   le_o              element output
module fpga_le
    import fpga_fabric_pkg::*;
(
    input  logic              clock,
    input  logic              rst,
    input  logic              ff_en_i,
    input  logic [LUT_W-1:0]  truth_i,
    input  logic              use_ff_i,
    input  logic              ce_en_i,
    input  logic              ce_i,
    input  logic [LE_INS-1:0] in_i,
    output logic              le_o
);

    logic lut_s;
    logic ff_d;
    logic ff_q;

    assign lut_s = truth_i[in_i];

    // FF next state: cleared while the fabric is disabled, loads when enabled or CE unused.
    always_comb begin
        ff_d = ff_q;
        if (!ff_en_i) begin
            ff_d = 1'b0;
        end else if (!ce_en_i || ce_i) begin
            ff_d = lut_s;
        end else begin
            ff_d = ff_q;
        end
    end

    // FF state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            ff_q <= 1'b0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign le_o = use_ff_i ? ff_q : lut_s;

endmodule

// File: rtl/fpga_fabric.sv
// fpga_fabric: configurable emulation fabric with 4 pad banks, NUM_LE LUT4+FF
// elements and a full crossbar from a 512-entry source space.
//   clock, rst  single clock; rst clears only the LE flip-flops
//   bus         fpga_fabric_if.slave (pads, ff_en, config write, optional readback)
// Optional feature macro: FPGA_FABRIC_CFG_READBACK_EN adds a registered
// config readback port (cfg_rd_addr -> cfg_rd_data, one cycle latency).
// Config memory has no reset and survives rst.
module fpga_fabric
    import fpga_fabric_pkg::*;
(
    input  logic         clock,
    input  logic         rst,
    fpga_fabric_if.slave bus
);

    logic [CFG_W-1:0]   cfg_q [CFG_WORDS];
    logic [SRC_W-1:0]   src_s;
    logic [NUM_LE-1:0]  le_out_s;
    logic [NUM_OUT-1:0] out_s;

    // Config store: every enabled slot captures the same data word.
    always_ff @(posedge clock) begin
        for (int w = 0; w < CFG_WORDS; w++) begin
            if (bus.configs_en[w]) begin
                cfg_q[w] <= bus.configs_in;
            end
        end
    end

    // Source space: pads, then LE outputs, then constant zeros.
    assign src_s = {{(SRC_W - SRC_ZERO_BASE){1'b0}}, le_out_s,
                    bus.right_in, bus.left_in, bus.bot_in, bus.top_in};

    for (genvar k = 0; k < NUM_LE; k++) begin : g_le
        le_cfg_t           cfg_s;
        logic [LE_INS-1:0] in_val_s;

        assign cfg_s = le_cfg_t'(cfg_q[k][LE_CFG_BITS-1:0]);

        for (genvar j = 0; j < LE_INS; j++) begin : g_in
            assign in_val_s[j] = src_s[cfg_s.in_sel[j]];
        end

        fpga_le u_le (
            .clock    (clock),
            .rst      (rst),
            .ff_en_i  (bus.ff_en),
            .truth_i  (cfg_s.truth),
            .use_ff_i (cfg_s.use_ff),
            .ce_en_i  (cfg_s.ce_en),
            .ce_i     (src_s[cfg_s.ce_sel]),
            .in_i     (in_val_s),
            .le_o     (le_out_s[k])
        );
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        localparam int WORD = out_word_idx(o);
        localparam int LSB  = out_sel_lsb(o);
        logic [SEL_W-1:0] sel_s;

        assign sel_s    = cfg_q[WORD][LSB +: SEL_W];
        assign out_s[o] = bus.ff_en ? src_s[sel_s] : 1'b0;
    end

    assign bus.top_out   = out_s[0*IO_W +: IO_W];
    assign bus.bot_out   = out_s[1*IO_W +: IO_W];
    assign bus.left_out  = out_s[2*IO_W +: IO_W];
    assign bus.right_out = out_s[3*IO_W +: IO_W];

`ifdef FPGA_FABRIC_CFG_READBACK_EN
    logic [CFG_W-1:0] rd_data_d;
    logic [CFG_W-1:0] rd_data_q;

    // Readback select: zero on reset or for addresses past the last slot.
    always_comb begin
        rd_data_d = {CFG_W{1'b0}};
        if (rst) begin
            rd_data_d = {CFG_W{1'b0}};
        end else if (bus.cfg_rd_addr < SEL_W'(CFG_WORDS)) begin
            rd_data_d = cfg_q[bus.cfg_rd_addr];
        end else begin
            rd_data_d = {CFG_W{1'b0}};
        end
    end

    // Readback data register.
    always_ff @(posedge clock) begin
        rd_data_q <= rd_data_d;
    end

    assign bus.cfg_rd_data = rd_data_q;
`else
    // Reserved slots and ignored word bits are stored but have no reader in this build.
    logic unused_cfg_s;

    // Fold of the stored-but-unread configuration bits.
    always_comb begin
        unused_cfg_s = 1'b0;
        for (int w = 0; w < NUM_LE; w++) begin
            unused_cfg_s = unused_cfg_s ^ (^cfg_q[w][CFG_W-1:LE_CFG_BITS]);
        end
        for (int w = OUT_WORD_BASE; w < USED_WORDS; w++) begin
            unused_cfg_s = unused_cfg_s ^ (^cfg_q[w][CFG_W-1:SEL_PER_WORD*SEL_W]);
        end
        for (int w = USED_WORDS; w < CFG_WORDS; w++) begin
            unused_cfg_s = unused_cfg_s ^ (^cfg_q[w]);
        end
    end
`endif

endmodule

// File: tb/tb_fpga_fabric.sv
// tb_fpga_fabric: directed, table-driven bench for fpga_fabric.
// Output index 192 is left_out[32]; its selector lives in word 68 bits [224:216].
// Source 193 is left_in[33], 201 is left_in[41], 320 is LE0, 511 is constant 0.
module tb_fpga_fabric;

    logic clock = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    fpga_fabric_if bus ();

    fpga_fabric dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ff_en;
        logic        l33;
        logic [79:0] noise;
        logic        exp_l32;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_outs(input string name, input logic exp_l32);
        logic [319:0] e;
        e      = '0;
        e[192] = exp_l32;
        check(name, {64'd0, bus.right_out, bus.left_out, bus.bot_out, bus.top_out}, {64'd0, e});
    endtask

    task automatic write_cfg(input logic [266:0] mask, input logic [383:0] data);
        bus.configs_en = mask;
        bus.configs_in = data;
        tick();
        bus.configs_en = '0;
    endtask

    initial begin
        logic [266:0] m;
        logic [383:0] w;
        logic [383:0] w0;
        logic [383:0] w0n;

        vecs[0] = '{1'b1, 1'b1, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 80'hA5A5_5A5A_A5A5_5A5A_A5A5, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 80'h1234_5678_9ABC_DEF0_1357, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 80'h0000_0000_0000_0000_0000, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b0};

        rst            = 1'b1;
        bus.ff_en      = 1'b0;
        bus.configs_en = '0;
        bus.configs_in = '0;
        bus.top_in     = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        bus.bot_in     = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        bus.left_in    = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        bus.right_in   = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
`ifdef FPGA_FABRIC_CFG_READBACK_EN
        bus.cfg_rd_addr = 9'd0;
`endif
        tick();
        tick();
        check_outs("reset_outputs_zero", 1'b0);
        rst = 1'b0;

        // Base config: LEs all zero (truth 0, comb), every output selector = 511 (constant 0).
        m = '0;
        for (int i = 0; i < 64; i++) m[i] = 1'b1;
        write_cfg(m, '0);
        m = '0;
        for (int i = 64; i < 72; i++) m[i] = 1'b1;
        w = '1;
        write_cfg(m, w);
        // left_out[32] <- left_in[33]
        w[216 +: 9] = 9'd193;
        m = '0;
        m[68] = 1'b1;
        write_cfg(m, w);

        // Pass-through and disable vectors
        for (int i = 0; i < 6; i++) begin
            bus.ff_en        = vecs[i].ff_en;
            bus.top_in       = vecs[i].noise;
            bus.bot_in       = ~vecs[i].noise;
            bus.right_in     = vecs[i].noise ^ 80'h0F0F_0F0F_0F0F_0F0F_0F0F;
            bus.left_in      = vecs[i].noise;
            bus.left_in[33]  = vecs[i].l33;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp_l32);
        end

        // Registered LE0 = left_in[33], left_out[32] <- LE0
        bus.ff_en    = 1'b1;
        bus.top_in   = '0;
        bus.bot_in   = '0;
        bus.right_in = '0;
        bus.left_in  = '0;
        w0 = '0;
        w0[8:0]   = 9'd193;
        w0[17:9]  = 9'd511;
        w0[26:18] = 9'd511;
        w0[35:27] = 9'd511;
        w0[51:36] = 16'hAAAA;
        w0[52]    = 1'b1;
        m = '0;
        m[0] = 1'b1;
        write_cfg(m, w0);
        w[216 +: 9] = 9'd320;
        m = '0;
        m[68] = 1'b1;
        write_cfg(m, w);

        bus.left_in[33] = 1'b1;
        #1;
        check_outs("reg_before_edge", 1'b0);
        tick();
        check_outs("reg_rise", 1'b1);
        bus.left_in[33] = 1'b0;
        #1;
        check_outs("reg_hold_until_edge", 1'b1);
        tick();
        check_outs("reg_fall", 1'b0);

        // Clock enable from left_in[41]; the write edge still loads with the old config.
        bus.left_in[33] = 1'b1;
        bus.left_in[41] = 1'b0;
        w0[53]    = 1'b1;
        w0[62:54] = 9'd201;
        m = '0;
        m[0] = 1'b1;
        write_cfg(m, w0);
        bus.left_in[33] = 1'b0;
        tick();
        check_outs("ce_hold_high", 1'b1);
        bus.left_in[41] = 1'b1;
        tick();
        check_outs("ce_load_low", 1'b0);
        bus.left_in[41] = 1'b0;
        bus.left_in[33] = 1'b1;
        tick();
        check_outs("ce_hold_low", 1'b0);
        bus.left_in[41] = 1'b1;
        tick();
        check_outs("ce_load_high", 1'b1);

        // Reset clears the FF but keeps configuration
        rst = 1'b1;
        tick();
        check_outs("rst_clears_ff", 1'b0);
        rst = 1'b0;
        tick();
        check_outs("rst_resume", 1'b1);

        // Multi-hot write to slot 0 and reserved slot 200: inverting registered LE
        w0n = w0;
        w0n[51:36] = 16'h5555;
        w0n[53]    = 1'b0;
        m = '0;
        m[0]   = 1'b1;
        m[200] = 1'b1;
        write_cfg(m, w0n);
        tick();
        check_outs("mh_invert_hi_in", 1'b0);
        bus.left_in[33] = 1'b0;
        tick();
        check_outs("mh_invert_lo_in", 1'b1);

`ifdef FPGA_FABRIC_CFG_READBACK_EN
        bus.cfg_rd_addr = 9'd200;
        tick();
        check("rd_slot200", bus.cfg_rd_data, w0n);
        bus.cfg_rd_addr = 9'd0;
        tick();
        check("rd_slot0", bus.cfg_rd_data, w0n);
        bus.cfg_rd_addr = 9'd300;
        tick();
        check("rd_out_of_range", bus.cfg_rd_data, '0);
        bus.cfg_rd_addr = 9'd0;
        rst = 1'b1;
        tick();
        check("rd_reset", bus.cfg_rd_data, '0);
        rst = 1'b0;
        tick();
`endif

        // Disable forces outputs low and clears the FF
        bus.ff_en = 1'b0;
        #1;
        check_outs("disable_outputs", 1'b0);
        tick();
        bus.ff_en       = 1'b1;
        bus.left_in[33] = 1'b1;
        #1;
        check_outs("reenable_ff_cleared", 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
